// File: rtl/chacha_pkg.sv
// chacha_pkg: shared types, rotation constants and helpers for the ChaCha quarter-round engine.
package chacha_pkg;
    typedef logic [31:0] word_t;
    localparam int unsigned QR_STEPS = 4;
    localparam int unsigned ROT0 = 16;
    localparam int unsigned ROT1 = 12;
    localparam int unsigned ROT2 = 8;
    localparam int unsigned ROT3 = 7;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    function automatic word_t rotl(input word_t v, input int unsigned r);
        return (v << r) | (v >> (32 - r));
    endfunction
endpackage

// File: rtl/chacha_arx_step.sv
// chacha_arx_step: one combinational add-xor-rotate step of the ChaCha quarter-round.
module chacha_arx_step
    import chacha_pkg::*;
(
    input  word_t      x,
    input  word_t      y,
    input  word_t      z,
    input  logic [1:0] idx,
    output word_t      x_o,
    output word_t      z_o
);
    int unsigned r;
    always_comb begin
        r   = idx == 2'd0 ? ROT0 : idx == 2'd1 ? ROT1 : idx == 2'd2 ? ROT2 : ROT3;
        x_o = x + y;
        z_o = rotl(z ^ x_o, r);
    end
endmodule

// File: rtl/chacha_qr_core.sv
// chacha_qr_core: iterative ChaCha quarter-round, UNROLL ARX steps per clock.
module chacha_qr_core
    import chacha_pkg::*;
#(
    parameter int UNROLL = 1
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  start,
    input  word_t a_in,
    input  word_t b_in,
    input  word_t c_in,
    input  word_t d_in,
    output logic  busy,
    output logic  done,
    output word_t a_out,
    output word_t b_out,
    output word_t c_out,
    output word_t d_out
);
    if (UNROLL != 1 && UNROLL != 2 && UNROLL != 4) begin : g_bad_unroll
        $error("chacha_qr_core: UNROLL must be 1, 2 or 4");
    end

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    word_t      a_q, b_q, c_q, d_q, a_d, b_d, c_d, d_d;
    word_t      a_s [UNROLL+1];
    word_t      b_s [UNROLL+1];
    word_t      c_s [UNROLL+1];
    word_t      d_s [UNROLL+1];

    assign a_s[0] = a_q;
    assign b_s[0] = b_q;
    assign c_s[0] = c_q;
    assign d_s[0] = d_q;

    // Even steps work on (a,b,d), odd steps on (c,d,b).
    for (genvar k = 0; k < UNROLL; k++) begin : g_step
        logic [1:0] idx;
        word_t      x, y, z, x_o, z_o;
        assign idx = cnt_q[1:0] + 2'(k);
        assign x   = idx[0] ? c_s[k] : a_s[k];
        assign y   = idx[0] ? d_s[k] : b_s[k];
        assign z   = idx[0] ? b_s[k] : d_s[k];
        chacha_arx_step u_step (
            .x  (x),
            .y  (y),
            .z  (z),
            .idx(idx),
            .x_o(x_o),
            .z_o(z_o)
        );
        assign a_s[k+1] = idx[0] ? a_s[k] : x_o;
        assign b_s[k+1] = idx[0] ? z_o : b_s[k];
        assign c_s[k+1] = idx[0] ? x_o : c_s[k];
        assign d_s[k+1] = idx[0] ? d_s[k] : z_o;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        d_d     = d_q;
        if (start && state_q != RUN) begin
            a_d     = a_in;
            b_d     = b_in;
            c_d     = c_in;
            d_d     = d_in;
            cnt_d   = '0;
            state_d = RUN;
        end else if (state_q == RUN) begin
            a_d     = a_s[UNROLL];
            b_d     = b_s[UNROLL];
            c_d     = c_s[UNROLL];
            d_d     = d_s[UNROLL];
            cnt_d   = cnt_q + 3'(UNROLL);
            state_d = cnt_d == 3'(QR_STEPS) ? DONE : RUN;
        end else begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            d_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            d_q     <= d_d;
        end
    end

    assign busy  = state_q == RUN;
    assign done  = state_q == DONE;
    assign a_out = a_q;
    assign b_out = b_q;
    assign c_out = c_q;
    assign d_out = d_q;
endmodule

// File: tb/tb_chacha_qr_core.sv
// tb_chacha_qr_core: directed vectors against UNROLL=1/2/4 instances sharing one stimulus.
module tb_chacha_qr_core;
    import chacha_pkg::*;

    logic  clk = 1'b0;
    logic  rst_n = 1'b0;
    logic  start = 1'b0;
    word_t a_in = '0, b_in = '0, c_in = '0, d_in = '0;
    logic  busy1, done1, busy2, done2, busy4, done4;
    word_t o1 [4];
    word_t o2 [4];
    word_t o4 [4];
    int    errs = 0;
    int    checks = 0;

    chacha_qr_core #(.UNROLL(1)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start),
        .a_in(a_in), .b_in(b_in), .c_in(c_in), .d_in(d_in),
        .busy(busy1), .done(done1),
        .a_out(o1[0]), .b_out(o1[1]), .c_out(o1[2]), .d_out(o1[3])
    );
    chacha_qr_core #(.UNROLL(2)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start),
        .a_in(a_in), .b_in(b_in), .c_in(c_in), .d_in(d_in),
        .busy(busy2), .done(done2),
        .a_out(o2[0]), .b_out(o2[1]), .c_out(o2[2]), .d_out(o2[3])
    );
    chacha_qr_core #(.UNROLL(4)) u4 (
        .clk(clk), .rst_n(rst_n), .start(start),
        .a_in(a_in), .b_in(b_in), .c_in(c_in), .d_in(d_in),
        .busy(busy4), .done(done4),
        .a_out(o4[0]), .b_out(o4[1]), .c_out(o4[2]), .d_out(o4[3])
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic chk_words(input string tag, input word_t got [4], input word_t e [4]);
        chk({tag, ".a"}, got[0], e[0]);
        chk({tag, ".b"}, got[1], e[1]);
        chk({tag, ".c"}, got[2], e[2]);
        chk({tag, ".d"}, got[3], e[3]);
    endtask

    // start in cycle 0; samples taken 1 time unit after each edge (cycle n = after edge n)
    task automatic run_vec(input string tag, input word_t v [4], input word_t e [4],
                           input bit scramble, input bit pulse);
        int dc [3];
        int nd [3];
        dc = '{-1, -1, -1};
        nd = '{0, 0, 0};
        @(posedge clk); #1;
        a_in = v[0]; b_in = v[1]; c_in = v[2]; d_in = v[3]; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int cyc = 1; cyc <= 10; cyc++) begin
            if (scramble && cyc <= 4) begin
                a_in = ~v[0]; b_in = v[1] ^ 32'h5a5a5a5a; c_in = 32'(cyc); d_in = ~v[3];
            end
            start = pulse && (cyc == 2 || cyc == 3);
            if (cyc == 1) chk({tag, ".busy_c1"}, 32'(busy1), 32'd1);
            if (done1) begin
                nd[0]++;
                if (dc[0] < 0) begin dc[0] = cyc; chk_words({tag, ".u1"}, o1, e); end
            end
            if (done2) begin
                nd[1]++;
                if (dc[1] < 0) begin dc[1] = cyc; chk_words({tag, ".u2"}, o2, e); end
            end
            if (done4) begin
                nd[2]++;
                if (dc[2] < 0) begin dc[2] = cyc; chk_words({tag, ".u4"}, o4, e); end
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        chk({tag, ".done_cyc_u1"}, 32'(dc[0]), 32'd5);
        chk({tag, ".done_cnt_u1"}, 32'(nd[0]), 32'd1);
        chk({tag, ".busy_end"}, 32'(busy1), 32'd0);
        chk_words({tag, ".u1_hold"}, o1, e);
        if (!pulse) begin
            chk({tag, ".done_cyc_u2"}, 32'(dc[1]), 32'd3);
            chk({tag, ".done_cyc_u4"}, 32'(dc[2]), 32'd2);
            chk({tag, ".done_cnt_u2"}, 32'(nd[1]), 32'd1);
            chk({tag, ".done_cnt_u4"}, 32'(nd[2]), 32'd1);
        end
    endtask

    word_t rfc_in [4]  = '{32'h11111111, 32'h01020304, 32'h9b8d6f43, 32'h01234567};
    word_t rfc_out [4] = '{32'hea2a92f4, 32'hcb1cf8ce, 32'h4581472e, 32'h5881c4bb};
    word_t zero [4]    = '{32'h0, 32'h0, 32'h0, 32'h0};
    word_t ones [4]    = '{32'hffffffff, 32'hffffffff, 32'hffffffff, 32'hffffffff};
    word_t ones_out [4] = '{32'hf0000ffd, 32'h88790878, 32'h0110fdef, 32'h010ffdf0};

    initial begin
        int d1 [2];
        int d4 [2];
        #12;
        chk("rst.busy", 32'(busy1), 32'd0);
        chk("rst.done", 32'(done1), 32'd0);
        chk_words("rst.u1", o1, zero);
        rst_n = 1'b1;

        run_vec("rfc", rfc_in, rfc_out, 1'b0, 1'b0);
        run_vec("zero", zero, zero, 1'b0, 1'b0);
        run_vec("ones", ones, ones_out, 1'b0, 1'b0);
        run_vec("pulse", rfc_in, rfc_out, 1'b0, 1'b1);
        run_vec("scramble", rfc_in, rfc_out, 1'b1, 1'b0);

        // start held high: a new run is accepted in every done cycle
        d1 = '{-1, -1};
        d4 = '{-1, -1};
        @(posedge clk); #1;
        a_in = rfc_in[0]; b_in = rfc_in[1]; c_in = rfc_in[2]; d_in = rfc_in[3]; start = 1'b1;
        for (int cyc = 0; cyc <= 12; cyc++) begin
            if (done1) begin
                if (d1[0] < 0) d1[0] = cyc;
                else if (d1[1] < 0) begin d1[1] = cyc; chk_words("b2b.u1", o1, rfc_out); end
            end
            if (done4) begin
                if (d4[0] < 0) d4[0] = cyc;
                else if (d4[1] < 0) d4[1] = cyc;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        chk("b2b.u1_first", 32'(d1[0]), 32'd5);
        chk("b2b.u1_second", 32'(d1[1]), 32'd10);
        chk("b2b.u4_first", 32'(d4[0]), 32'd2);
        chk("b2b.u4_second", 32'(d4[1]), 32'd4);
        repeat (6) @(posedge clk);
        #1;

        // asynchronous reset in the middle of cycle 3
        a_in = rfc_in[0]; b_in = rfc_in[1]; c_in = rfc_in[2]; d_in = rfc_in[3]; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk); #3;
        chk("arst.busy_before", 32'(busy1), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("arst.busy", 32'(busy1), 32'd0);
        chk("arst.done", 32'(done1), 32'd0);
        chk("arst.busy_u2", 32'(busy2), 32'd0);
        chk_words("arst.u1", o1, zero);
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_vec("after_rst", rfc_in, rfc_out, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
